// File: rtl/inst_slot_packer.sv
// Serial-to-parallel instruction packer: fills slots 0..INPUT_SLOT-1 in order from a
// valid/ready stream and offers each sealed line, with a per-slot valid mask, downstream.
module inst_slot_packer #(
    parameter int INPUT_SLOT  = 4,
    parameter int INST_LENGTH = 32
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic [INST_LENGTH-1:0]                 inst_in,
    input  logic                                   inst_valid,
    output logic                                   inst_ready,
    input  logic                                   flush_in,
    output logic [INPUT_SLOT-1:0][INST_LENGTH-1:0] line_out,
    output logic [INPUT_SLOT-1:0]                  line_mask,
    output logic                                   line_valid,
    input  logic                                   line_ready,
    output logic [$clog2(INPUT_SLOT):0]            fill_count
);

    localparam int PW = $clog2(INPUT_SLOT);
    localparam logic [PW-1:0] LAST_SLOT = PW'(INPUT_SLOT - 1);

    // state | meaning
    // FILL  | building a line, accepting one instruction per cycle
    // HOLD  | sealed line offered; a transfer may start the next line in the same cycle
    typedef enum logic {FILL, HOLD} state_t;

    state_t                                 state_q, state_d;
    logic [PW-1:0]                          wr_ptr_q, wr_ptr_d;
    logic [PW:0]                            fill_count_q, fill_count_d;
    logic [INPUT_SLOT-1:0][INST_LENGTH-1:0] slots_q, slots_d;
    logic [INPUT_SLOT-1:0]                  mask_q, mask_d;
    logic                                   accept;

    assign inst_ready = (state_q == FILL) | line_ready;
    assign accept     = inst_valid & inst_ready;
    assign line_valid = (state_q == HOLD);
    assign line_out   = slots_q;
    assign line_mask  = mask_q;
    assign fill_count = fill_count_q;

    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        fill_count_d = fill_count_q;
        slots_d      = slots_q;
        mask_d       = mask_q;
        case (state_q)
            FILL: begin
                if (accept) begin
                    slots_d[wr_ptr_q] = inst_in;
                    mask_d[wr_ptr_q]  = 1'b1;
                    fill_count_d      = fill_count_q + 1'b1;
                    if (wr_ptr_q == LAST_SLOT || flush_in) begin
                        state_d  = HOLD;
                        wr_ptr_d = '0;
                    end else begin
                        wr_ptr_d = wr_ptr_q + 1'b1;
                    end
                end else if (flush_in && fill_count_q != '0) begin
                    state_d  = HOLD;
                    wr_ptr_d = '0;
                end
            end
            HOLD: begin
                if (line_ready) begin
                    state_d      = FILL;
                    slots_d      = '0;
                    mask_d       = '0;
                    fill_count_d = '0;
                    wr_ptr_d     = '0;
                    // Back-to-back: the instruction taken during the transfer opens the next line.
                    if (inst_valid) begin
                        slots_d[0]   = inst_in;
                        mask_d[0]    = 1'b1;
                        fill_count_d = (PW+1)'(1);
                        if (flush_in) begin
                            state_d = HOLD;
                        end else begin
                            wr_ptr_d = PW'(1);
                        end
                    end
                end
            end
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= FILL;
            wr_ptr_q     <= '0;
            fill_count_q <= '0;
            slots_q      <= '0;
            mask_q       <= '0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            fill_count_q <= fill_count_d;
            slots_q      <= slots_d;
            mask_q       <= mask_d;
        end
    end

endmodule
